// File: rtl/sram_controller.sv
// sram_controller: runs each 32-bit load/store as two 16-bit accesses on an
// asynchronous SRAM. The low half goes first, then the high half. While an
// access is in flight, ready stays low and the pipeline uses it to freeze.
module sram_controller #(
  parameter int          SRAM_WAIT = 2,
  parameter logic [31:0] MEM_BASE  = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] row_q, row_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        last;
  logic        active;
  logic [18:0] off;
  logic        unused_bits;

  assign req  = wr_en | rd_en;
  assign last = (cnt_q == 4'(SRAM_WAIT - 1));

  // Only off[18:2] selects an SRAM row. The low 19 bits of a modulo-2^32
  // difference depend only on the low 19 bits of each operand.
  assign off         = address[18:0] - MEM_BASE[18:0];
  assign unused_bits = ^{address[31:19], off[1:0]};

  // State and datapath registers. Reset drops any access that is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      row_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      row_q   <= row_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: latch the request in IDLE, hold each half for SRAM_WAIT
  // cycles, and sample read data on the last cycle of each half.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    row_d   = row_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = wr_en;              // a write wins when both are set
          row_d   = off[18:2];
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
          cnt_d   = '0;
          state_d = S_HI;
        end
      end
      S_HI: begin
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;       // DONE ignores requests for one cycle
    endcase
  end

  // Bus outputs are decoded from registered state only, so they change on
  // clock edges and stay stable for the whole wait window of each half.
  assign active    = (state_q == S_LO) || (state_q == S_HI);
  assign SRAM_ADDR = active ? {row_q, state_q == S_HI} : 18'd0;
  assign SRAM_WE_N = !(active && wr_q);
  assign SRAM_DQ   = (active && wr_q)
                     ? ((state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0])
                     : 16'hzzzz;

  assign ready     = !rst || (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
  assign read_data = rdata_q;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage responder for the pipeline's load/store commands. It accepts a 32-bit read or write request from the EX/MEM register, performs it as two 16-bit accesses on an external asynchronous SRAM, and holds `ready` low until the access completes. The pipeline uses `~ready` as its freeze signal, so every stage register upstream holds while an access is in progress.

## Interface
- `SRAM_WAIT`, default 2: cycles each 16-bit half-access is held on the SRAM bus. Legal range 1..15.
- `MEM_BASE`, default 1024: byte address that maps to SRAM halfword 0.
- `clk` in 1: pipeline clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: store request from the EX/MEM register.
- `rd_en` in 1: load request from the EX/MEM register.
- `address` in 32: byte address, word aligned.
- `write_data` in 32: store data.
- `read_data` out 32: load result, registered.
- `ready` out 1: access complete, or no access pending.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_WE_N` out 1: SRAM write strobe, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: constant 0.

## Operation
- Address math: `off = address - MEM_BASE`, taken modulo 2^32. `SRAM_ADDR = {off[18:2], half}`, where `half` is 0 for the low half and 1 for the high half. Bits `off[1:0]` and `off[31:19]` are ignored.
- States: IDLE, LO, HI, DONE. A wait counter of 4 bits runs during LO and HI.
- IDLE:
  - If `wr_en | rd_en`, latch `address`, `write_data` and the operation, clear the counter, and go to LO.
  - If both are set, the operation is a write and `read_data` is left untouched.
- LO:
  - Drive `SRAM_ADDR` with `half = 0`.
  - For a write, drive `SRAM_WE_N = 0` and `SRAM_DQ = wdata[15:0]`.
  - For a read, drive `SRAM_WE_N = 1` and leave `SRAM_DQ` at high-Z.
  - The counter increments every cycle. When it reaches `SRAM_WAIT-1`: for a read, capture `SRAM_DQ` into `read_data[15:0]`; then clear the counter and go to HI.
- HI: same as LO, with `half = 1`, data `wdata[31:16]`, and capture into `read_data[31:16]`. On exit go to DONE.
- DONE: one cycle, then go to IDLE. Request inputs are ignored in DONE, because the pipeline has not yet advanced.
- `ready` is combinational:
  - 1 in DONE.
  - 1 in IDLE when `wr_en | rd_en` is 0.
  - 0 otherwise, including IDLE with a request present.
- `SRAM_WE_N` is 1 in IDLE and DONE. `SRAM_DQ` is high-Z whenever the block is not in the LO or HI state of a write.
- Reset (`rst = 0`, asynchronous):
  - State goes to IDLE, counter to 0, `read_data` to 0, latched request to 0.
  - `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, `SRAM_ADDR = 0`.
  - `ready = 1` while reset is held.
- Reset mid-access aborts the access. Bus and outputs take reset values within the same cycle, and a partially captured `read_data` is discarded.

## Timing
- A request first seen in IDLE at cycle t gives:
  - LO in cycles t+1 .. t+SRAM_WAIT.
  - HI in cycles t+SRAM_WAIT+1 .. t+2·SRAM_WAIT.
  - DONE at t+2·SRAM_WAIT+1.
- `ready` is low for 2·SRAM_WAIT+1 cycles (t .. t+2·SRAM_WAIT), then high for one cycle.
- `read_data` is valid from DONE onward and holds until the next read completes.
- The requester holds `wr_en`, `rd_en`, `address` and `write_data` stable until it samples `ready = 1`. Changes during LO or HI have no effect.
- Back-to-back requests: a request present at DONE+1 (IDLE) starts a new access immediately, with no idle bubble beyond DONE.
- Bus setup: `SRAM_ADDR`, `SRAM_DQ` and `SRAM_WE_N` change only on clock edges, and are stable for the whole SRAM_WAIT window of each half.

## Test plan
- Reset: hold `rst = 0` with `wr_en = 1` → `ready = 1`, `read_data = 0`, `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, `SRAM_ADDR = 0`.
- Write, SRAM_WAIT = 2: `address = 1024`, `write_data = 0xDEADBEEF` →
  - `SRAM_ADDR` is 0 for 2 cycles with DQ `0xBEEF`, then 1 for 2 cycles with DQ `0xDEAD`.
  - `SRAM_WE_N = 0` across all 4 cycles.
  - `ready` is low for 5 cycles, then high for 1.
- Read back with an SRAM model: `rd_en`, `address = 1024` → `read_data = 0xDEADBEEF` at DONE, and `SRAM_WE_N` stays 1 throughout.
- Address map: write at `address = 1028` → `SRAM_ADDR` is 2 then 3. Write at `address = 1024 + 0x7FFFC` → `SRAM_ADDR` is `0x3FFFE` then `0x3FFFF`.
- Back-to-back plus conflict:
  - Write then read issued on consecutive ready pulses → the second access starts the cycle after DONE.
  - `wr_en = rd_en = 1` → the write is performed and `read_data` is unchanged.
- Reset mid-access: assert `rst = 0` during HI of a read → immediate IDLE, `read_data = 0`, DQ high-Z. After release, a new read completes with full latency.
